// File: rtl/riscv_core_dpath_vector_wb_seq_pkg.sv
// riscv_core_dpath_vector_wb_seq_pkg: shared lane count, VLMAX and FSM encoding for the vector writeback sequencer
package riscv_CoreVectorPkg;
    localparam int LANES = 4;
    localparam int VLMAX = 64;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_FILL = 1'b1;
    function automatic logic [6:0] eff_vl(input logic [6:0] vl);
        return (vl > 7'(VLMAX)) ? 7'(VLMAX) : vl;
    endfunction
endpackage

// File: rtl/riscv_core_dpath_vector_wb_seq.sv
// riscv_core_dpath_vector_wb_seq: packs in-order result elements into 4-lane groups and issues one regfile write per group
// Ports: cmd_* accepts a writeback command (vd, vl, inter); elem_* streams result elements;
// kill aborts the active command; v_*_p / v_lanes / v_winter form the registered write; done pulses on completion.
module riscv_core_dpath_vector_wb_seq
    import riscv_CoreVectorPkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_val,
    output logic         cmd_rdy,
    input  logic [4:0]   cmd_vd,
    input  logic [6:0]   cmd_vl,
    input  logic         cmd_inter,
    input  logic         elem_val,
    output logic         elem_rdy,
    input  logic [31:0]  elem_data,
    input  logic         kill,
    output logic         v_wen_p,
    output logic [4:0]   v_waddr_p,
    output logic [5:0]   v_widx_p,
    output logic [127:0] v_wdata_p,
    output logic [1:0]   v_lanes,
    output logic         v_winter,
    output logic         done
);
    logic                   state_q, state_d;
    logic [4:0]             vd_q, vd_d;
    logic                   inter_q, inter_d;
    logic [6:0]             vl_q, vl_d;
    logic [6:0]             cnt_q, cnt_d;
    logic [LANES-1:0][31:0] buf_q, buf_d;
    logic                   wen_q, wen_d;
    logic [4:0]             waddr_q, waddr_d;
    logic [5:0]             widx_q, widx_d;
    logic [127:0]           wdata_q, wdata_d;
    logic [1:0]             lanes_q, lanes_d;
    logic                   winter_q, winter_d;
    logic                   done_q, done_d;
    logic [1:0]             lane;
    logic [6:0]             cnt_inc, vl_eff;
    logic                   last, close;
    always_comb begin
        state_d  = state_q;
        vd_d     = vd_q;
        inter_d  = inter_q;
        vl_d     = vl_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        widx_d   = widx_q;
        wdata_d  = wdata_q;
        lanes_d  = lanes_q;
        winter_d = winter_q;
        done_d   = 1'b0;
        lane     = cnt_q[1:0];
        cnt_inc  = cnt_q + 7'd1;
        vl_eff   = eff_vl(cmd_vl);
        last     = cnt_inc == vl_q;
        close    = (lane == 2'd3) || last;
        if (state_q == ST_IDLE) begin
            if (cmd_val) begin
                vd_d    = cmd_vd;
                inter_d = cmd_inter;
                vl_d    = vl_eff;
                cnt_d   = '0;
                buf_d   = '0;
                state_d = (vl_eff == 7'd0) ? ST_IDLE : ST_FILL;
                done_d  = vl_eff == 7'd0;
            end
        end else if (kill) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            buf_d   = '0;
        end else if (elem_val) begin
            cnt_d       = cnt_inc;
            buf_d[lane] = elem_data;
            if (close) begin
                wen_d    = 1'b1;
                waddr_d  = vd_q;
                winter_d = inter_q;
                widx_d   = {cnt_q[5:2], 2'b00};
                lanes_d  = lane;
                for (int k = 0; k < LANES; k++)
                    wdata_d[32*k +: 32] = (k <= int'(lane)) ? buf_d[k] : 32'd0;
                buf_d    = '0;
                state_d  = last ? ST_IDLE : ST_FILL;
                done_d   = last;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            vd_q     <= '0;
            inter_q  <= 1'b0;
            vl_q     <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            widx_q   <= '0;
            wdata_q  <= '0;
            lanes_q  <= '0;
            winter_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vd_q     <= vd_d;
            inter_q  <= inter_d;
            vl_q     <= vl_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            widx_q   <= widx_d;
            wdata_q  <= wdata_d;
            lanes_q  <= lanes_d;
            winter_q <= winter_d;
            done_q   <= done_d;
        end
    end
    assign cmd_rdy   = state_q == ST_IDLE;
    assign elem_rdy  = state_q == ST_FILL;
    assign v_wen_p   = wen_q;
    assign v_waddr_p = waddr_q;
    assign v_widx_p  = widx_q;
    assign v_wdata_p = wdata_q;
    assign v_lanes   = lanes_q;
    assign v_winter  = winter_q;
    assign done      = done_q;
endmodule

// File: tb/tb_riscv_core_dpath_vector_wb_seq.sv
// tb_riscv_core_dpath_vector_wb_seq: directed scoreboard bench for the vector writeback sequencer
module tb_riscv_core_dpath_vector_wb_seq;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_val, cmd_rdy, cmd_inter;
    logic [4:0]   cmd_vd;
    logic [6:0]   cmd_vl;
    logic         elem_val, elem_rdy, kill;
    logic [31:0]  elem_data;
    logic         v_wen_p, v_winter, done;
    logic [4:0]   v_waddr_p;
    logic [5:0]   v_widx_p;
    logic [127:0] v_wdata_p;
    logic [1:0]   v_lanes;

    typedef struct {
        logic [5:0]   idx;
        logic [1:0]   lanes;
        logic [127:0] data;
        logic [4:0]   addr;
        logic         inter;
        logic         done;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   exp_done_only = 0;

    riscv_core_dpath_vector_wb_seq dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_vd(cmd_vd), .cmd_vl(cmd_vl), .cmd_inter(cmd_inter),
        .elem_val(elem_val), .elem_rdy(elem_rdy), .elem_data(elem_data), .kill(kill),
        .v_wen_p(v_wen_p), .v_waddr_p(v_waddr_p), .v_widx_p(v_widx_p), .v_wdata_p(v_wdata_p),
        .v_lanes(v_lanes), .v_winter(v_winter), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (v_wen_p === 1'b1) begin
                chk("sb_nonempty", 128'(q.size() != 0), 128'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("widx", 128'(v_widx_p), 128'(e.idx));
                    chk("lanes", 128'(v_lanes), 128'(e.lanes));
                    chk("wdata", v_wdata_p, e.data);
                    chk("waddr", 128'(v_waddr_p), 128'(e.addr));
                    chk("winter", 128'(v_winter), 128'(e.inter));
                    chk("done_with_write", 128'(done), 128'(e.done));
                end
            end else if (done === 1'b1) begin
                chk("done_only_expected", 128'(exp_done_only > 0), 128'd1);
                if (exp_done_only > 0) exp_done_only--;
            end
        end
    end

    // vd/vl/inter: command; base: element i carries base+i+1; n_send: elements delivered;
    // do_kill: kill (with elem_val) after n_send; gaps: random idle cycles; do_rst: async reset after n_send
    task automatic run(input int vd, input int vl, input bit inter, input int base, input int n_send,
                       input bit do_kill, input bit gaps, input bit do_rst);
        int   eff, n, w;
        exp_t x;
        eff = (vl > 64) ? 64 : vl;
        for (int s = 0; s < eff; s += 4) begin
            n = (eff - s < 4) ? eff - s : 4;
            if (s + n - 1 < n_send) begin
                x.idx   = 6'(s);
                x.lanes = 2'(n - 1);
                x.data  = '0;
                for (int k = 0; k < n; k++) x.data[32*k +: 32] = 32'(base + s + k + 1);
                x.addr  = 5'(vd);
                x.inter = inter;
                x.done  = (s + n == eff);
                q.push_back(x);
            end
        end
        if (eff == 0) exp_done_only++;
        w = 0;
        while (cmd_rdy !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("cmd_rdy_ready", 128'(cmd_rdy), 128'd1);
        cmd_val = 1'b1; cmd_vd = 5'(vd); cmd_vl = 7'(vl); cmd_inter = inter;
        @(posedge clk); #1;
        cmd_val = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                elem_val = 1'b0;
                @(posedge clk); #1;
            end
            chk("elem_rdy_fill", 128'(elem_rdy), 128'd1);
            elem_val = 1'b1; elem_data = 32'(base + i + 1);
            @(posedge clk); #1;
            elem_val = 1'b0;
        end
        if (do_kill) begin
            elem_val = 1'b1; kill = 1'b1; elem_data = 32'hdead_beef;
            @(posedge clk); #1;
            elem_val = 1'b0; kill = 1'b0;
            chk("idle_after_kill", 128'(cmd_rdy), 128'd1);
        end
        if (do_rst) begin
            #2 reset_n = 1'b0;
            #1;
            chk("rst_cmd_rdy", 128'(cmd_rdy), 128'd1);
            chk("rst_elem_rdy", 128'(elem_rdy), 128'd0);
            chk("rst_outputs", {v_wdata_p, v_widx_p, v_waddr_p, v_lanes, v_winter, v_wen_p, done}, '0);
            @(posedge clk); #1;
            reset_n = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 128'(q.size()), 128'd0);
        chk("done_only_drained", 128'(exp_done_only), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; cmd_val = 1'b0; cmd_vd = '0; cmd_vl = '0; cmd_inter = 1'b0;
        elem_val = 1'b0; elem_data = '0; kill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_rdy", 128'(cmd_rdy), 128'd1);
        chk("reset_elem_rdy", 128'(elem_rdy), 128'd0);
        chk("reset_outputs", {v_wdata_p, v_widx_p, v_waddr_p, v_lanes, v_winter, v_wen_p, done}, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run(3, 8, 1'b0, 0, 8, 1'b0, 1'b0, 1'b0);
        run(9, 6, 1'b1, 100, 6, 1'b0, 1'b0, 1'b0);
        chk("hold_widx", 128'(v_widx_p), 128'd4);
        chk("hold_waddr", 128'(v_waddr_p), 128'd9);
        chk("hold_winter", 128'(v_winter), 128'd1);
        chk("hold_wdata", v_wdata_p, {64'd0, 32'd106, 32'd105});
        run(5, 64, 1'b0, 1000, 64, 1'b0, 1'b1, 1'b0);
        run(2, 5, 1'b0, 200, 3, 1'b1, 1'b0, 1'b0);
        run(4, 1, 1'b0, 300, 1, 1'b0, 1'b0, 1'b0);
        run(7, 100, 1'b1, 400, 64, 1'b0, 1'b0, 1'b0);
        run(6, 4, 1'b0, 500, 2, 1'b0, 1'b0, 1'b1);
        elem_val = 1'b1; elem_data = 32'h1234_5678;
        repeat (2) begin
            chk("idle_elem_rdy", 128'(elem_rdy), 128'd0);
            @(posedge clk); #1;
        end
        elem_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_elem_ignored", 128'(q.size()), 128'd0);
        run(1, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
